// File: rtl/nn_feature_sequencer.sv
// rtl/nn_feature_sequencer.sv - captures a sonar sample, streams features to a serial net, latches its results
module nn_feature_sequencer #(
  parameter int N_FEAT  = 60,
  parameter int W       = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [N_FEAT*W-1:0]   uzorak,
  output logic [W-1:0]          feat_data,
  output logic [5:0]            feat_idx,
  output logic                  feat_valid,
  output logic                  feat_last,
  input  logic                  feat_ready,
  input  logic                  res_valid,
  input  logic [W-1:0]          izlaz_1,
  input  logic [W-1:0]          izlaz_2,
  output logic [W-1:0]          rezultat_1,
  output logic [W-1:0]          rezultat_2,
  output logic                  indikator_1,
  output logic                  indikator_2,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [N_FEAT*W-1:0] shreg_q, shreg_d;
  logic [5:0]          idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                feat_valid_q, feat_valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;
  logic [W-1:0]        rez1_q, rez1_d;
  logic [W-1:0]        rez2_q, rez2_d;
  logic                ind1_q, ind1_d;
  logic                ind2_q, ind2_d;

  logic                is_last;

  // Feature 0 sits in the top slice; each accepted feature shifts the next one up.
  assign is_last     = (idx_q == 6'(N_FEAT - 1));
  assign feat_data   = shreg_q[N_FEAT*W-1 -: W];
  assign feat_idx    = idx_q;
  assign feat_valid  = feat_valid_q;
  assign feat_last   = feat_valid_q & is_last;
  assign rezultat_1  = rez1_q;
  assign rezultat_2  = rez2_q;
  assign indikator_1 = ind1_q;
  assign indikator_2 = ind2_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

  // Next-state and registered-output computation; abort overrides everything but reset.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    feat_valid_d = feat_valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    error_d      = error_q;
    rez1_d       = rez1_q;
    rez2_d       = rez2_q;
    ind1_d       = ind1_q;
    ind2_d       = ind2_q;

    if (abort) begin
      state_d      = S_IDLE;
      feat_valid_d = 1'b0;
      busy_d       = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shreg_d = uzorak;
            idx_d   = '0;
            cnt_d   = '0;
            error_d = 1'b0;
            rez1_d  = '0;
            rez2_d  = '0;
            ind1_d  = 1'b0;
            ind2_d  = 1'b0;
            busy_d  = 1'b1;
            state_d = S_LOAD;
          end
        end
        S_LOAD: begin
          feat_valid_d = 1'b1;
          state_d      = S_STREAM;
        end
        S_STREAM: begin
          if (feat_valid_q && feat_ready) begin
            shreg_d = shreg_q << W;
            if (is_last) begin
              feat_valid_d = 1'b0;
              cnt_d        = '0;
              state_d      = S_WAIT;
            end else begin
              idx_d = idx_q + 6'd1;
            end
          end
        end
        S_WAIT: begin
          cnt_d = cnt_q + CW'(1);
          // A result arriving on the terminal count still counts as success.
          if (res_valid) begin
            rez1_d  = izlaz_1;
            rez2_d  = izlaz_2;
            ind1_d  = ($signed(izlaz_1) > $signed(izlaz_2));
            ind2_d  = ~($signed(izlaz_1) > $signed(izlaz_2));
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            error_d = 1'b1;
            rez1_d  = '0;
            rez2_d  = '0;
            ind1_d  = 1'b0;
            ind2_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d      = S_IDLE;
          feat_valid_d = 1'b0;
          busy_d       = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      feat_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      rez1_q       <= '0;
      rez2_q       <= '0;
      ind1_q       <= 1'b0;
      ind2_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      feat_valid_q <= feat_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      rez1_q       <= rez1_d;
      rez2_q       <= rez2_d;
      ind1_q       <= ind1_d;
      ind2_q       <= ind2_d;
    end
  end

endmodule

// File: tb/tb_nn_feature_sequencer.sv
// tb/tb_nn_feature_sequencer.sv - self-checking bench for nn_feature_sequencer
module tb_nn_feature_sequencer;

  localparam int N_FEAT  = 60;
  localparam int W       = 16;
  localparam int TIMEOUT = 1023;

  logic                clk = 1'b0;
  logic                reset, start, abort;
  logic [N_FEAT*W-1:0] uzorak;
  logic [W-1:0]        feat_data;
  logic [5:0]          feat_idx;
  logic                feat_valid, feat_last, feat_ready, res_valid;
  logic [W-1:0]        izlaz_1, izlaz_2, rezultat_1, rezultat_2;
  logic                indikator_1, indikator_2, busy, done, error;

  nn_feature_sequencer #(.N_FEAT(N_FEAT), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .uzorak(uzorak),
    .feat_data(feat_data), .feat_idx(feat_idx), .feat_valid(feat_valid),
    .feat_last(feat_last), .feat_ready(feat_ready), .res_valid(res_valid),
    .izlaz_1(izlaz_1), .izlaz_2(izlaz_2), .rezultat_1(rezultat_1),
    .rezultat_2(rezultat_2), .indikator_1(indikator_1), .indikator_2(indikator_2),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] f0;
    logic [15:0] i1;
    logic [15:0] i2;
    logic        e1;
    logic        e2;
  } vec_t;

  vec_t tbl [6];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [N_FEAT*W-1:0] rnd_smp();
    logic [N_FEAT*W-1:0] s;
    for (int i = 0; i < N_FEAT*W/32; i++) s[i*32 +: 32] = $urandom;
    return s;
  endfunction

  function automatic logic [W-1:0] feat_of(input logic [N_FEAT*W-1:0] s, input int i);
    return s[(N_FEAT-1-i)*W +: W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction. ready_pct<0 selects the 1,0,0,1 ready pattern.
  // res_delay counts cycles spent in WAIT_RES before res_valid; >= TIMEOUT never sends it.
  task automatic run_txn(input logic [N_FEAT*W-1:0] smp, input int ready_pct,
                         input int res_delay, input logic [W-1:0] i1,
                         input logic [W-1:0] i2, input bit noise);
    int   hs, n, cyc, last_cyc;
    bit   rdy, exp_to, exp_i1;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    exp_to = (res_delay > TIMEOUT - 1);
    exp_i1 = exp_to ? 1'b0 : ($signed(i1) > $signed(i2));

    start = 1'b1; uzorak = smp; feat_ready = 1'b0; res_valid = 1'b0;
    tick(); start = 1'b0; cyc = 1;
    chk("load_busy", 32'(busy), 1);
    chk("load_valid", 32'(feat_valid), 0);
    chk("load_error_clr", 32'(error), 0);
    chk("load_rez1_clr", 32'(rezultat_1), 0);
    chk("load_ind_clr", 32'({indikator_1, indikator_2}), 0);

    hs = 0; n = 0; last_cyc = 0;
    while (hs < N_FEAT && n < 4000) begin
      tick(); cyc++; n++;
      start = 1'b0; res_valid = 1'b0;
      if (n == 1) chk("first_valid_at_2", 32'(feat_valid), 1);
      if (feat_valid) begin
        chk("feat_data", 32'(feat_data), 32'(feat_of(smp, hs)));
        chk("feat_idx", 32'(feat_idx), 32'(hs));
        chk("feat_last", 32'(feat_last), 32'(hs == N_FEAT - 1));
      end
      if (ready_pct < 0) rdy = pat[(n - 1) % 4];
      else rdy = ($urandom_range(99) < 32'(ready_pct));
      feat_ready = rdy;
      if (noise) begin
        start = 1'($urandom_range(1));
        res_valid = 1'($urandom_range(1));
        izlaz_1 = W'($urandom);
        izlaz_2 = W'($urandom);
      end
      if (feat_valid && rdy) begin
        hs++;
        last_cyc = cyc;
      end
    end
    chk("handshakes", 32'(hs), N_FEAT);
    if (ready_pct == 100) chk("last_hs_cycle", 32'(last_cyc), 61);

    tick(); start = 1'b0; res_valid = 1'b0; feat_ready = 1'b0;
    chk("wait_valid_low", 32'(feat_valid), 0);
    chk("wait_busy", 32'(busy), 1);
    for (int j = 0; j <= TIMEOUT; j++) begin
      if (j < 4) chk("wait_no_done", 32'(done), 0);
      izlaz_1 = W'($urandom); izlaz_2 = W'($urandom);
      if (j == res_delay) begin
        res_valid = 1'b1; izlaz_1 = i1; izlaz_2 = i2;
      end
      tick(); res_valid = 1'b0;
      if (j == res_delay || j == TIMEOUT - 1) break;
    end

    chk("done_pulse", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_error", 32'(error), 32'(exp_to));
    chk("rezultat_1", 32'(rezultat_1), exp_to ? 32'd0 : 32'(i1));
    chk("rezultat_2", 32'(rezultat_2), exp_to ? 32'd0 : 32'(i2));
    chk("indikator_1", 32'(indikator_1), 32'(exp_i1));
    chk("indikator_2", 32'(indikator_2), exp_to ? 32'd0 : 32'(!exp_i1));
    if (noise) begin
      res_valid = 1'b1; izlaz_1 = ~i1; izlaz_2 = ~i2;
    end
    tick(); res_valid = 1'b0;
    chk("done_one_cycle", 32'(done), 0);
    tick();
    chk("rez1_hold", 32'(rezultat_1), exp_to ? 32'd0 : 32'(i1));
    chk("error_hold", 32'(error), 32'(exp_to));
  endtask

  initial begin
    logic [N_FEAT*W-1:0] smp;
    int guard;

    tbl[0] = '{16'h12ef, 16'h0100, 16'hFF00, 1'b1, 1'b0};
    tbl[1] = '{16'h0001, 16'hFF00, 16'h0100, 1'b0, 1'b1};
    tbl[2] = '{16'hABCD, 16'h1234, 16'h1234, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h7FFF, 16'h8000, 1'b1, 1'b0};
    tbl[4] = '{16'h7FFF, 16'h8000, 16'h7FFF, 1'b0, 1'b1};
    tbl[5] = '{16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0};

    reset = 1'b1; start = 1'b1; abort = 1'b0; uzorak = rnd_smp();
    feat_ready = 1'b1; res_valid = 1'b0; izlaz_1 = '0; izlaz_2 = '0;
    repeat (3) begin
      tick();
      chk("rst_outputs", {feat_data, feat_idx, feat_valid, feat_last, busy, done, error,
                          indikator_1, indikator_2}, 0);
      chk("rst_rez", {rezultat_1, rezultat_2}, 0);
    end
    reset = 1'b0; start = 1'b0;
    tick();
    chk("post_rst_idle", 32'({busy, feat_valid}), 0);

    for (int i = 0; i < 6; i++) begin
      smp = rnd_smp();
      smp[N_FEAT*W-1 -: W] = tbl[i].f0;
      run_txn(smp, 100, 3 + i, tbl[i].i1, tbl[i].i2, 1'b0);
      chk("tbl_ind1", 32'(indikator_1), 32'(tbl[i].e1));
      chk("tbl_ind2", 32'(indikator_2), 32'(tbl[i].e2));
    end

    run_txn(rnd_smp(), -1, 0, 16'h0042, 16'h0041, 1'b0);

    run_txn(rnd_smp(), 100, TIMEOUT, 16'h5555, 16'h1111, 1'b0);
    tick();
    chk("timeout_error_held", 32'(error), 1);
    run_txn(rnd_smp(), 100, TIMEOUT - 1, 16'h0010, 16'h0020, 1'b0);

    smp = rnd_smp();
    start = 1'b1; uzorak = smp; tick(); start = 1'b0; feat_ready = 1'b1;
    guard = 0;
    while (!(feat_valid && feat_idx == 6'd20) && guard < 100) begin
      tick(); guard++;
    end
    chk("abort_reach_idx20", 32'(feat_idx), 20);
    abort = 1'b1; tick(); abort = 1'b0; feat_ready = 1'b0;
    chk("abort_valid", 32'(feat_valid), 0);
    chk("abort_busy", 32'(busy), 0);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_done", 32'(done), 0);
      tick();
    end
    run_txn(rnd_smp(), 100, 2, 16'hFFFE, 16'hFFFF, 1'b0);

    for (int t = 0; t < 15; t++) begin
      int d;
      d = (t == 7) ? TIMEOUT : ((t == 11) ? TIMEOUT - 1 : int'($urandom_range(40)));
      run_txn(rnd_smp(), int'($urandom_range(100, 20)), d, W'($urandom), W'($urandom), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
